// File: rtl/apb_ctrl_pkg.sv
// Shared types and bus widths for the round-robin APB master.
package apb_ctrl_pkg;
    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;
endpackage

// File: rtl/apb_master_arbiter_if.sv
// Requester-side handshake plus APB port of the arbitrated master.
interface apb_master_arbiter_if #(
    parameter int N_REQ = 4
);
    import apb_ctrl_pkg::*;

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_write;
    logic [N_REQ*APB_ADDR_W-1:0] req_addr;
    logic [N_REQ*APB_DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]            req_done;
    logic [APB_DATA_W-1:0]       rsp_rdata;
    logic                        rsp_err;

    logic [APB_ADDR_W-1:0]       paddr;
    logic                        psel;
    logic                        penable;
    logic                        pwrite;
    logic [APB_DATA_W-1:0]       pwdata;
    logic [APB_DATA_W-1:0]       prdata;
    logic                        pready;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, prdata, pready,
        output req_done, rsp_rdata, rsp_err, paddr, psel, penable, pwrite, pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, prdata, pready,
        input  req_done, rsp_rdata, rsp_err, paddr, psel, penable, pwrite, pwdata
    );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin pick: first pending request after last_i, wrapping.
module apb_rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] last_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [$clog2(N_REQ)-1:0] gnt_idx_o
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last_i) + k) % N_REQ);
            if (gnt_o == '0 && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
            end
        end
    end
endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin APB master: shares one psel among N_REQ requesters, with optional
// ACCESS-phase timeout that completes the transfer with rsp_err set.
module apb_master_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 pclk,
    input  logic                 preset,
    apb_master_arbiter_if.master bus_if
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t                state_q;
    logic [IDX_W-1:0]      last_q;
    logic [N_REQ-1:0]      grant_q;
    logic [N_REQ-1:0]      done_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic                  err_q;
    logic [APB_ADDR_W-1:0] paddr_q;
    logic [APB_DATA_W-1:0] pwdata_q;
    logic [APB_DATA_W-1:0] rdata_q;

    logic [N_REQ-1:0]      gnt_oh;
    logic [IDX_W-1:0]      gnt_idx;
    logic [APB_ADDR_W-1:0] addr_arr  [N_REQ];
    logic [APB_DATA_W-1:0] wdata_arr [N_REQ];
    logic                  timeout_hit;

    apb_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_i     (bus_if.req_valid),
        .last_i    (last_q),
        .gnt_o     (gnt_oh),
        .gnt_idx_o (gnt_idx)
    );

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            addr_arr[i]  = bus_if.req_addr[i*APB_ADDR_W +: APB_ADDR_W];
            wdata_arr[i] = bus_if.req_wdata[i*APB_DATA_W +: APB_DATA_W];
        end
    end

    // The counter starts at 0 in the first ACCESS cycle, so TIMEOUT-1 marks the last allowed one.
    assign timeout_hit = (TIMEOUT != 0) && (int'(cnt_q) == TIMEOUT - 1);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q   <= IDLE;
            last_q    <= IDX_W'(N_REQ - 1);
            grant_q   <= '0;
            done_q    <= '0;
            cnt_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            err_q     <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
        end else begin
            done_q <= '0;
            case (state_q)
                IDLE: begin
                    if (gnt_oh != '0) begin
                        grant_q  <= gnt_oh;
                        last_q   <= gnt_idx;
                        paddr_q  <= addr_arr[gnt_idx];
                        pwrite_q <= bus_if.req_write[gnt_idx];
                        pwdata_q <= bus_if.req_write[gnt_idx] ? wdata_arr[gnt_idx] : '0;
                        psel_q   <= 1'b1;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (bus_if.pready || timeout_hit) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        done_q    <= grant_q;
                        err_q     <= !bus_if.pready;
                        rdata_q   <= (bus_if.pready && !pwrite_q) ? bus_if.prdata : '0;
                        state_q   <= IDLE;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_if.req_done  = done_q;
    assign bus_if.rsp_rdata = rdata_q;
    assign bus_if.rsp_err   = err_q;
    assign bus_if.paddr     = paddr_q;
    assign bus_if.psel      = psel_q;
    assign bus_if.penable   = penable_q;
    assign bus_if.pwrite    = pwrite_q;
    assign bus_if.pwdata    = pwdata_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scenario bench for apb_master_arbiter: scoreboard of expected completions plus
// cycle-accurate checks of the APB phases, wait states, timeout and reset.
module tb_apb_master_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic pclk = 1'b0;
    logic preset;

    apb_master_arbiter_if #(.N_REQ(N)) bus ();

    apb_master_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus_if (bus)
    );

    always #5 pclk = ~pclk;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          slave_wait = 0;
    int          acc_n = 0;
    logic [31:0] slave_rdata = 32'h0;
    logic [N-1:0] done_or = '0;

    // Advance to the next falling edge and play the APB slave for this cycle.
    task automatic tick();
        @(negedge pclk);
        done_or = done_or | bus.req_done;
        if (bus.psel && bus.penable) begin
            bus.pready = (acc_n >= slave_wait);
            acc_n++;
        end else begin
            bus.pready = 1'b0;
            acc_n = 0;
        end
        bus.prdata = slave_rdata;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
        bus.req_valid[i]          = 1'b1;
        bus.req_write[i]          = wr;
        bus.req_addr[i*32 +: 32]  = a;
        bus.req_wdata[i*32 +: 32] = d;
    endtask

    task automatic push_exp(input int idx, input logic [31:0] rd, input logic er);
        exp_t e;
        e.idx   = idx;
        e.rdata = rd;
        e.err   = er;
        sb.push_back(e);
    endtask

    task automatic reset_dut();
        bus.req_valid = '0;
        preset = 1'b1;
        tick();
        tick();
        preset = 1'b0;
    endtask

    task automatic test_reset();
        preset = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.pwrite !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: psel=%b penable=%b pwrite=%b required 0 0 0", bus.psel, bus.penable, bus.pwrite);
        end
        checks++;
        if (bus.paddr !== 32'h0 || bus.pwdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: paddr=%h pwdata=%h required 0 0", bus.paddr, bus.pwdata);
        end
        checks++;
        if (bus.req_done !== 4'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rsp: done=%b err=%b rdata=%h required 0", bus.req_done, bus.rsp_err, bus.rsp_rdata);
        end
        preset = 1'b0;
        tick();
        checks++;
        if (bus.psel !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: psel=%b required 0", bus.psel);
        end
    endtask

    task automatic test_single_write();
        exp_t e;
        slave_wait  = 0;
        slave_rdata = 32'hDEADBEEF;
        set_req(0, 1'b1, 32'h10, 32'hA5A5A5A5);
        push_exp(0, 32'h0, 1'b0);
        tick();
        checks++;
        if (bus.psel !== 1'b1 || bus.penable !== 1'b0 || bus.paddr !== 32'h10 || bus.pwrite !== 1'b1) begin
            errors++;
            $display("FAIL wr_setup: psel=%b penable=%b paddr=%h pwrite=%b required 1 0 00000010 1", bus.psel, bus.penable, bus.paddr, bus.pwrite);
        end
        tick();
        checks++;
        if (bus.psel !== 1'b1 || bus.penable !== 1'b1 || bus.pwdata !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL wr_access: psel=%b penable=%b pwdata=%h required 1 1 a5a5a5a5", bus.psel, bus.penable, bus.pwdata);
        end
        tick();
        checks++;
        if (bus.req_done !== 4'b0001 || bus.psel !== 1'b0) begin
            errors++;
            $display("FAIL wr_done: done=%b psel=%b required 0001 0", bus.req_done, bus.psel);
        end
        bus.req_valid[0] = 1'b0;
        e = sb.pop_front();
        checks++;
        if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
            errors++;
            $display("FAIL wr_rsp: rdata=%h err=%b required %h %b", bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
        end
        tick();
        checks++;
        if (bus.req_done !== 4'b0000) begin
            errors++;
            $display("FAIL wr_done_pulse: done=%b required 0000", bus.req_done);
        end
    endtask

    task automatic test_read_wait();
        exp_t e;
        int n;
        int moved;
        slave_wait  = 3;
        slave_rdata = 32'h12345678;
        set_req(2, 1'b0, 32'h2000_0040, 32'hFFFF_FFFF);
        push_exp(2, 32'h12345678, 1'b0);
        n = 0;
        moved = 0;
        do begin
            tick();
            n++;
            if (bus.psel && bus.paddr !== 32'h2000_0040) moved++;
            if (bus.penable && bus.pwdata !== 32'h0) moved++;
        end while (bus.req_done === 4'b0 && n < 40);
        checks++;
        if (n != 6 || bus.req_done !== 4'b0100) begin
            errors++;
            $display("FAIL rd_latency: cycles=%0d done=%b required 6 0100", n, bus.req_done);
        end
        bus.req_valid[2] = 1'b0;
        e = sb.pop_front();
        checks++;
        if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
            errors++;
            $display("FAIL rd_rsp: rdata=%h err=%b required %h %b", bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
        end
        checks++;
        if (moved != 0) begin
            errors++;
            $display("FAIL rd_stable: unstable paddr/pwdata cycles=%0d required 0", moved);
        end
        tick();
    endtask

    task automatic test_round_robin();
        exp_t e;
        int n;
        int multi;
        reset_dut();
        slave_wait  = 0;
        slave_rdata = 32'hCAFEF00D;
        for (int i = 0; i < N; i++) set_req(i, (i % 2) == 1, 32'h100 + 32'(i * 4), 32'h5000 + 32'(i));
        push_exp(0, 32'hCAFEF00D, 1'b0);
        push_exp(1, 32'h0, 1'b0);
        push_exp(2, 32'hCAFEF00D, 1'b0);
        push_exp(3, 32'h0, 1'b0);
        push_exp(0, 32'hCAFEF00D, 1'b0);
        multi = 0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            do begin
                tick();
                n++;
                if ($countones(bus.req_done) > 1) multi++;
            end while (bus.req_done === 4'b0 && n < 40);
            if (k == 4) bus.req_valid = '0;
            e = sb.pop_front();
            checks++;
            if (n != 3 || bus.req_done !== (4'b0001 << e.idx)) begin
                errors++;
                $display("FAIL rr_grant%0d: cycles=%0d done=%b required 3 req%0d", k, n, bus.req_done, e.idx);
            end
            checks++;
            if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
                errors++;
                $display("FAIL rr_rsp%0d: rdata=%h err=%b required %h %b", k, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
            end
        end
        checks++;
        if (multi != 0) begin
            errors++;
            $display("FAIL rr_onehot: multi-bit done cycles=%0d required 0", multi);
        end
        tick();
    endtask

    task automatic test_timeout();
        exp_t e;
        int n;
        slave_wait  = 1000;
        slave_rdata = 32'h55AA55AA;
        set_req(1, 1'b0, 32'h3000, 32'h0);
        push_exp(1, 32'h0, 1'b1);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.req_done === 4'b0 && n < 60);
        checks++;
        if (n != 18 || bus.req_done !== 4'b0010) begin
            errors++;
            $display("FAIL to_latency: cycles=%0d done=%b required 18 0010", n, bus.req_done);
        end
        bus.req_valid[1] = 1'b0;
        e = sb.pop_front();
        checks++;
        if (bus.rsp_err !== e.err || bus.rsp_rdata !== e.rdata) begin
            errors++;
            $display("FAIL to_rsp: err=%b rdata=%h required %b %h", bus.rsp_err, bus.rsp_rdata, e.err, e.rdata);
        end
        checks++;
        if (bus.psel !== 1'b0 || bus.penable !== 1'b0) begin
            errors++;
            $display("FAIL to_release: psel=%b penable=%b required 0 0", bus.psel, bus.penable);
        end
        tick();
        checks++;
        if (bus.req_done !== 4'b0 || bus.psel !== 1'b0) begin
            errors++;
            $display("FAIL to_idle: done=%b psel=%b required 0000 0", bus.req_done, bus.psel);
        end
        slave_wait = 0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int n;
        slave_wait  = 1000;
        slave_rdata = 32'h0F0F0F0F;
        set_req(0, 1'b0, 32'h40, 32'h0);
        tick();
        tick();
        checks++;
        if (bus.penable !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_access: penable=%b required 1", bus.penable);
        end
        preset = 1'b1;
        #1;
        checks++;
        if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.req_done !== 4'b0) begin
            errors++;
            $display("FAIL rst_async: psel=%b penable=%b done=%b required 0 0 0000", bus.psel, bus.penable, bus.req_done);
        end
        bus.req_valid = '0;
        tick();
        done_or     = '0;
        preset      = 1'b0;
        slave_wait  = 0;
        set_req(0, 1'b0, 32'h40, 32'h0);
        set_req(1, 1'b1, 32'h44, 32'h1111);
        push_exp(0, 32'h0F0F0F0F, 1'b0);
        push_exp(1, 32'h0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (bus.req_done === 4'b0 && n < 40);
            e = sb.pop_front();
            bus.req_valid[e.idx] = 1'b0;
            checks++;
            if (n != 3 || bus.req_done !== (4'b0001 << e.idx) || bus.rsp_rdata !== e.rdata) begin
                errors++;
                $display("FAIL rst_regrant%0d: cycles=%0d done=%b rdata=%h required 3 req%0d %h", k, n, bus.req_done, bus.rsp_rdata, e.idx, e.rdata);
            end
        end
        tick();
    endtask

    task automatic test_withdraw();
        exp_t e;
        int n;
        slave_wait  = 3;
        slave_rdata = 32'h0BAD0BAD;
        done_or     = '0;
        set_req(0, 1'b0, 32'h50, 32'h0);
        push_exp(0, 32'h0BAD0BAD, 1'b0);
        tick();
        set_req(1, 1'b0, 32'h54, 32'h0);
        set_req(3, 1'b0, 32'h5C, 32'h0);
        push_exp(3, 32'h0BAD0BAD, 1'b0);
        tick();
        bus.req_valid[1] = 1'b0;
        n = 2;
        for (int k = 0; k < 2; k++) begin
            do begin
                tick();
                n++;
            end while (bus.req_done === 4'b0 && n < 40);
            e = sb.pop_front();
            bus.req_valid[e.idx] = 1'b0;
            checks++;
            if (n != 6 || bus.req_done !== (4'b0001 << e.idx) || bus.rsp_rdata !== e.rdata) begin
                errors++;
                $display("FAIL wd_grant%0d: cycles=%0d done=%b rdata=%h required 6 req%0d %h", k, n, bus.req_done, bus.rsp_rdata, e.idx, e.rdata);
            end
            n = 0;
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (done_or[1] !== 1'b0 || bus.req_done !== 4'b0) begin
            errors++;
            $display("FAIL wd_no_done1: seen=%b done=%b required bit1 0", done_or, bus.req_done);
        end
    endtask

    initial begin
        preset        = 1'b1;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.prdata    = '0;
        bus.pready    = 1'b0;
        test_reset();
        test_single_write();
        test_read_wait();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_withdraw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
